id_i_queue: RTL and testbench

//  Parametrised, buffered successor to the I-type decoder. Accepts raw instruction words with

---
 rtl/id_i_queue_if.sv | 30 +++
 rtl/id_i_queue.sv | 136 +++++++++++++
 tb/tb_id_i_queue.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/id_i_queue_if.sv
// id_i_queue_if: fetch-side push and execute-side pop handshakes of the decode queue.
interface id_i_queue_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
);
    logic                      flush;
    logic                      in_valid;
    logic                      in_ready;
    logic [31:0]               in_inst_code;
    logic [DATA_WIDTH-1:0]     in_pc;
    logic                      out_valid;
    logic                      out_ready;
    logic [7:0]                out_inst;
    logic [4:0]                out_reg_s;
    logic [4:0]                out_reg_t;
    logic [DATA_WIDTH-1:0]     out_imm_ext;
    logic [DATA_WIDTH-1:0]     out_pc;
    logic                      out_invalid;
    logic [$clog2(DEPTH):0]    count;
    modport master (
        output flush, in_valid, in_inst_code, in_pc, out_ready,
        input  in_ready, out_valid, out_inst, out_reg_s, out_reg_t, out_imm_ext, out_pc,
               out_invalid, count
    );
    modport slave (
        input  flush, in_valid, in_inst_code, in_pc, out_ready,
        output in_ready, out_valid, out_inst, out_reg_s, out_reg_t, out_imm_ext, out_pc,
               out_invalid, count
    );
endinterface

// File: rtl/id_i_queue.sv
// id_i_queue: decodes I-type/REGIMM/CP0 words on entry and buffers the decoded entries in a FIFO.
module id_i_queue #(
    parameter int DATA_WIDTH       = 32,
    parameter int DEPTH            = 4,
    parameter bit ENABLE_CP0       = 1'b1,
    parameter bit ENABLE_UNALIGNED = 1'b1
) (
    input logic         clk,
    input logic         rst,
    id_i_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [7:0] INST_INVALID = 8'd0,  INST_BEQ   = 8'd1,  INST_BNE   = 8'd2,
                           INST_BLEZ    = 8'd3,  INST_BGTZ  = 8'd4,  INST_BLTZ  = 8'd5,
                           INST_BGEZ    = 8'd6,  INST_ADDIU = 8'd7,  INST_SLTI  = 8'd8,
                           INST_SLTIU   = 8'd9,  INST_ANDI  = 8'd10, INST_ORI   = 8'd11,
                           INST_XORI    = 8'd12, INST_LUI   = 8'd13, INST_LB    = 8'd14,
                           INST_LH      = 8'd15, INST_LWL   = 8'd16, INST_LW    = 8'd17,
                           INST_LBU     = 8'd18, INST_LHU   = 8'd19, INST_LWR   = 8'd20,
                           INST_SB      = 8'd21, INST_SH    = 8'd22, INST_SWL   = 8'd23,
                           INST_SW      = 8'd24, INST_SWR   = 8'd25, INST_MFC0  = 8'd26,
                           INST_MTC0    = 8'd27, INST_TLBWI = 8'd28, INST_ERET  = 8'd29;

    typedef struct packed {
        logic [7:0]            inst;
        logic [4:0]            rs;
        logic [4:0]            rt;
        logic [DATA_WIDTH-1:0] imm;
        logic [DATA_WIDTH-1:0] pc;
        logic                  invalid;
    } entry_t;

    localparam entry_t RST_ENTRY = '{inst: INST_INVALID, rs: '0, rt: '0, imm: '0, pc: '0, invalid: 1'b0};

    logic [5:0]            op;
    logic [4:0]            rs;
    logic [4:0]            rt;
    logic [5:0]            funct;
    logic [15:0]           imm;
    logic [7:0]            dec_inst;
    logic [DATA_WIDTH-1:0] dec_imm;
    entry_t                dec_entry;

    assign op    = bus.in_inst_code[31:26];
    assign rs    = bus.in_inst_code[25:21];
    assign rt    = bus.in_inst_code[20:16];
    assign funct = bus.in_inst_code[5:0];
    assign imm   = bus.in_inst_code[15:0];

    always_comb begin
        dec_inst = INST_INVALID;
        case (op)
            6'h01: dec_inst = (rt == 5'h00) ? INST_BLTZ : (rt == 5'h01) ? INST_BGEZ : INST_INVALID;
            6'h04: dec_inst = INST_BEQ;
            6'h05: dec_inst = INST_BNE;
            6'h06: dec_inst = INST_BLEZ;
            6'h07: dec_inst = INST_BGTZ;
            6'h09: dec_inst = INST_ADDIU;
            6'h0a: dec_inst = INST_SLTI;
            6'h0b: dec_inst = INST_SLTIU;
            6'h0c: dec_inst = INST_ANDI;
            6'h0d: dec_inst = INST_ORI;
            6'h0e: dec_inst = INST_XORI;
            6'h0f: dec_inst = INST_LUI;
            6'h10: dec_inst = !ENABLE_CP0                   ? INST_INVALID :
                              (rs == 5'd0)                  ? INST_MFC0    :
                              (rs == 5'd4)                  ? INST_MTC0    :
                              (rs[4] && funct == 6'h02)     ? INST_TLBWI   :
                              (rs[4] && funct == 6'h18)     ? INST_ERET    : INST_INVALID;
            6'h20: dec_inst = INST_LB;
            6'h21: dec_inst = INST_LH;
            6'h22: dec_inst = ENABLE_UNALIGNED ? INST_LWL : INST_INVALID;
            6'h23: dec_inst = INST_LW;
            6'h24: dec_inst = INST_LBU;
            6'h25: dec_inst = INST_LHU;
            6'h26: dec_inst = ENABLE_UNALIGNED ? INST_LWR : INST_INVALID;
            6'h28: dec_inst = INST_SB;
            6'h29: dec_inst = INST_SH;
            6'h2a: dec_inst = ENABLE_UNALIGNED ? INST_SWL : INST_INVALID;
            6'h2b: dec_inst = INST_SW;
            6'h2e: dec_inst = ENABLE_UNALIGNED ? INST_SWR : INST_INVALID;
            default: dec_inst = INST_INVALID;
        endcase
    end

    // Logical immediates zero-extend, LUI pre-shifts; everything else (invalid included) sign-extends.
    assign dec_imm = (dec_inst == INST_ANDI || dec_inst == INST_ORI || dec_inst == INST_XORI) ? DATA_WIDTH'(imm) :
                     (dec_inst == INST_LUI) ? DATA_WIDTH'({imm, 16'h0000}) :
                     {{(DATA_WIDTH-16){imm[15]}}, imm};

    assign dec_entry = '{inst: dec_inst, rs: rs, rt: rt, imm: dec_imm, pc: bus.in_pc,
                         invalid: dec_inst == INST_INVALID};

    entry_t         mem_q [DEPTH];
    entry_t         head;
    logic [AW-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]  count_q, count_d;
    logic           full, not_empty, push, pop;

    assign full      = count_q == CW'(DEPTH);
    assign not_empty = count_q != '0;
    assign push      = bus.in_valid && !full && !bus.flush;
    assign pop       = not_empty && bus.out_ready && !bus.flush;

    always_comb begin
        wr_d    = bus.flush ? '0 : push ? wr_q + 1'b1 : wr_q;
        rd_d    = bus.flush ? '0 : pop ? rd_q + 1'b1 : rd_q;
        count_d = bus.flush ? '0 : count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= RST_ENTRY;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            if (push) mem_q[wr_q] <= dec_entry;
        end
    end

    assign head            = mem_q[rd_q];
    assign bus.in_ready    = !full;
    assign bus.out_valid   = not_empty;
    assign bus.out_inst    = head.inst;
    assign bus.out_reg_s   = head.rs;
    assign bus.out_reg_t   = head.rt;
    assign bus.out_imm_ext = head.imm;
    assign bus.out_pc      = head.pc;
    assign bus.out_invalid = head.invalid;
    assign bus.count       = count_q;
endmodule

// File: tb/tb_id_i_queue.sv
// tb_id_i_queue: directed decode vectors plus FIFO fill, flush and reset sequences.
module tb_id_i_queue;
    localparam int DW = 32;
    localparam int DEPTH = 4;
    localparam logic [7:0] I_INVALID = 8'd0,  I_BEQ  = 8'd1,  I_BGEZ = 8'd6,  I_ADDIU = 8'd7,
                           I_ANDI    = 8'd10, I_ORI  = 8'd11, I_LUI  = 8'd13, I_LWL   = 8'd16,
                           I_LW      = 8'd17, I_SW   = 8'd24, I_MFC0 = 8'd26, I_MTC0  = 8'd27,
                           I_TLBWI   = 8'd28, I_ERET = 8'd29;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    id_i_queue_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) if0 ();
    id_i_queue_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) if1 ();

    id_i_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ENABLE_CP0(1'b1), .ENABLE_UNALIGNED(1'b1))
        u0 (.clk(clk), .rst(rst), .bus(if0));
    id_i_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ENABLE_CP0(1'b0), .ENABLE_UNALIGNED(1'b0))
        u1 (.clk(clk), .rst(rst), .bus(if1));

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] code;
        logic [31:0] pc;
        logic [7:0]  e0;
        logic [7:0]  e1;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] imm;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] code, input logic [31:0] pc,
                         input logic ordy, input logic fl);
        if0.in_valid = v; if0.in_inst_code = code; if0.in_pc = pc; if0.out_ready = ordy; if0.flush = fl;
        if1.in_valid = v; if1.in_inst_code = code; if1.in_pc = pc; if1.out_ready = ordy; if1.flush = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{32'h3421ABCD, 32'h100, I_ORI,     I_ORI,     5'd1, 5'd1, 32'h0000ABCD};
        vecs[1]  = '{32'h2402FFFF, 32'h104, I_ADDIU,   I_ADDIU,   5'd0, 5'd2, 32'hFFFFFFFF};
        vecs[2]  = '{32'h3C01ABCD, 32'h108, I_LUI,     I_LUI,     5'd0, 5'd1, 32'hABCD0000};
        vecs[3]  = '{32'h04110000, 32'h10C, I_INVALID, I_INVALID, 5'd0, 5'd17, 32'h00000000};
        vecs[4]  = '{32'h40806000, 32'h110, I_MTC0,    I_INVALID, 5'd4, 5'd0, 32'h00006000};
        vecs[5]  = '{32'h8C430004, 32'h114, I_LW,      I_LW,      5'd2, 5'd3, 32'h00000004};
        vecs[6]  = '{32'h88A6FFF8, 32'h118, I_LWL,     I_INVALID, 5'd5, 5'd6, 32'hFFFFFFF8};
        vecs[7]  = '{32'h1000FFFE, 32'h11C, I_BEQ,     I_BEQ,     5'd0, 5'd0, 32'hFFFFFFFE};
        vecs[8]  = '{32'h3084FF00, 32'h120, I_ANDI,    I_ANDI,    5'd4, 5'd4, 32'h0000FF00};
        vecs[9]  = '{32'h42000018, 32'h124, I_ERET,    I_INVALID, 5'd16, 5'd0, 32'h00000018};
        vecs[10] = '{32'h04010010, 32'h128, I_BGEZ,    I_BGEZ,    5'd0, 5'd1, 32'h00000010};
        vecs[11] = '{32'hFC000000, 32'h12C, I_INVALID, I_INVALID, 5'd0, 5'd0, 32'h00000000};
        vecs[12] = '{32'h42000002, 32'h130, I_TLBWI,   I_INVALID, 5'd16, 5'd0, 32'h00000002};
        vecs[13] = '{32'hAC000010, 32'h134, I_SW,      I_SW,      5'd0, 5'd0, 32'h00000010};
        vecs[14] = '{32'h40002800, 32'h138, I_MFC0,    I_INVALID, 5'd0, 5'd0, 32'h00002800};
        vecs[15] = '{32'h42000001, 32'h13C, I_INVALID, I_INVALID, 5'd16, 5'd0, 32'h00000001};

        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1 rst = 1'b1;
        #2;
        chk("rst count", 64'(if0.count), 64'd0);
        chk("rst out_valid", 64'(if0.out_valid), 64'd0);
        chk("rst in_ready", 64'(if0.in_ready), 64'd1);
        chk("rst out_inst", 64'(if0.out_inst), 64'(I_INVALID));
        chk("rst out_invalid", 64'(if0.out_invalid), 64'd0);
        chk("rst out_imm_ext", 64'(if0.out_imm_ext), 64'd0);
        chk("rst out_pc", 64'(if0.out_pc), 64'd0);
        chk("rst out_reg_s", 64'(if0.out_reg_s), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Decode table: push one word, inspect the head next cycle, then pop it.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, vecs[i].code, vecs[i].pc, 1'b0, 1'b0);
            tick();
            drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
            chk($sformatf("v%0d count", i), 64'(if0.count), 64'd1);
            chk($sformatf("v%0d out_valid", i), 64'(if0.out_valid), 64'd1);
            chk($sformatf("v%0d inst", i), 64'(if0.out_inst), 64'(vecs[i].e0));
            chk($sformatf("v%0d inst_nocp0", i), 64'(if1.out_inst), 64'(vecs[i].e1));
            chk($sformatf("v%0d invalid", i), 64'(if0.out_invalid), 64'(vecs[i].e0 == I_INVALID));
            chk($sformatf("v%0d invalid_nocp0", i), 64'(if1.out_invalid), 64'(vecs[i].e1 == I_INVALID));
            chk($sformatf("v%0d reg_s", i), 64'(if0.out_reg_s), 64'(vecs[i].rs));
            chk($sformatf("v%0d reg_t", i), 64'(if0.out_reg_t), 64'(vecs[i].rt));
            chk($sformatf("v%0d imm", i), 64'(if0.out_imm_ext), 64'(vecs[i].imm));
            chk($sformatf("v%0d imm_nocp0", i), 64'(if1.out_imm_ext), 64'(vecs[i].imm));
            chk($sformatf("v%0d pc", i), 64'(if0.out_pc), 64'(vecs[i].pc));
            drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            tick();
            chk($sformatf("v%0d count_after_pop", i), 64'(if0.count), 64'd0);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Back-to-back pushes come out in order.
        drive(1'b1, 32'h2402FFFF, 32'h104, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h3C01ABCD, 32'h108, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("order count", 64'(if0.count), 64'd2);
        chk("order first imm", 64'(if0.out_imm_ext), 64'hFFFFFFFF);
        chk("order first inst", 64'(if0.out_inst), 64'(I_ADDIU));
        tick();
        chk("order second imm", 64'(if0.out_imm_ext), 64'hABCD0000);
        chk("order second inst", 64'(if0.out_inst), 64'(I_LUI));
        chk("order count1", 64'(if0.count), 64'd1);
        tick();
        chk("order count0", 64'(if0.count), 64'd0);

        // Fill to DEPTH, refuse extra push, then push+pop while full.
        for (int k = 0; k < DEPTH; k++) begin
            drive(1'b1, 32'h24000000 | 32'(k), 32'h200 + 32'(4 * k), 1'b0, 1'b0);
            tick();
        end
        chk("full count", 64'(if0.count), 64'(DEPTH));
        chk("full in_ready", 64'(if0.in_ready), 64'd0);
        chk("full out_valid", 64'(if0.out_valid), 64'd1);
        drive(1'b1, 32'h24000063, 32'h300, 1'b0, 1'b0);
        tick();
        chk("full extra count", 64'(if0.count), 64'(DEPTH));
        chk("full head stable pc", 64'(if0.out_pc), 64'h200);
        drive(1'b1, 32'h24000063, 32'h300, 1'b1, 1'b0);
        tick();
        chk("full pushpop count", 64'(if0.count), 64'(DEPTH - 1));
        chk("full pushpop in_ready", 64'(if0.in_ready), 64'd1);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        for (int k = 1; k < DEPTH; k++) begin
            chk($sformatf("drain%0d pc", k), 64'(if0.out_pc), 64'h200 + 64'(4 * k));
            chk($sformatf("drain%0d imm", k), 64'(if0.out_imm_ext), 64'(k));
            tick();
        end
        chk("drain count", 64'(if0.count), 64'd0);
        chk("drain out_valid", 64'(if0.out_valid), 64'd0);

        // Flush with a same-cycle push and pop request.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h34000001 + 32'(k), 32'h380 + 32'(4 * k), 1'b0, 1'b0);
            tick();
        end
        chk("preflush count", 64'(if0.count), 64'd3);
        drive(1'b1, 32'h24000077, 32'h400, 1'b1, 1'b1);
        tick();
        chk("flush count", 64'(if0.count), 64'd0);
        chk("flush out_valid", 64'(if0.out_valid), 64'd0);
        chk("flush in_ready", 64'(if0.in_ready), 64'd1);
        drive(1'b1, 32'h24000055, 32'h404, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("postflush count", 64'(if0.count), 64'd1);
        chk("postflush pc", 64'(if0.out_pc), 64'h404);
        chk("postflush imm", 64'(if0.out_imm_ext), 64'h55);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        chk("postflush pop", 64'(if0.count), 64'd0);

        // Asynchronous reset between clock edges clears the queue at once.
        drive(1'b1, 32'h3421ABCD, 32'h500, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h2402FFFF, 32'h504, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("prereset count", 64'(if0.count), 64'd2);
        #2 rst = 1'b1;
        #1;
        chk("async rst count", 64'(if0.count), 64'd0);
        chk("async rst out_valid", 64'(if0.out_valid), 64'd0);
        chk("async rst out_pc", 64'(if0.out_pc), 64'd0);
        chk("async rst out_inst", 64'(if0.out_inst), 64'(I_INVALID));
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("after rst count", 64'(if0.count), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
